// File: rtl/aes_selftest_monitor.sv
// Sequencer for the AES all-modes self-test wrapper: enables it, waits for the datapaths to settle,
// confirms the six pass flags are stable and latches them onto LEDs. Optional blink: AES_SELFTEST_BLINK_EN.
module aes_selftest_monitor #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int CONFIRM_CYCLES = 4,
  parameter int MAX_RETRIES    = 8,
  parameter int BLINK_HALF     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] pass_in,
  output logic       wrap_enable,
  output logic [5:0] led,
  output logic       all_pass,
  output logic       unstable,
  output logic       busy,
  output logic       done
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int CW = $clog2(CONFIRM_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES) + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CONFIRM_N   = CW'(CONFIRM_CYCLES);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CONFIRM = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SW-1:0]   r_settle_cnt;
  logic [CW-1:0]   r_stable_cnt;
  logic [RW-1:0]   r_retry_cnt;
  logic [5:0]      r_snap;
  logic [5:0]      r_result;
  logic            r_unstable;

  logic [SW-1:0]   w_settle_nxt;
  logic [CW-1:0]   w_stable_nxt;
  logic [RW-1:0]   w_retry_nxt;
  logic [5:0]      w_snap_nxt;
  logic [5:0]      w_result_nxt;
  logic            w_unstable_nxt;

  logic            w_mismatch;
  logic [5:0]      w_led_fail;

  logic            w_wrap_nxt;
  logic [5:0]      w_led_nxt;
  logic            w_all_pass_nxt;
  logic            w_unstable_out_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // A mismatch only exists once a reference sample has been taken in this attempt.
  assign w_mismatch = (r_stable_cnt != '0) && (pass_in != r_snap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) w_state_nxt = S_CONFIRM;
      end
      S_CONFIRM: begin
        if (r_stable_cnt != '0) begin
          if (w_mismatch) begin
            if (r_retry_cnt == RETRY_LAST) w_state_nxt = S_DONE;
          end else if (r_stable_cnt == CONFIRM_N) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) w_state_nxt = S_SETTLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_settle_nxt   = r_settle_cnt;
    w_stable_nxt   = r_stable_cnt;
    w_retry_nxt    = r_retry_cnt;
    w_snap_nxt     = r_snap;
    w_result_nxt   = r_result;
    w_unstable_nxt = r_unstable;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_settle_nxt = '0;
          w_retry_nxt  = '0;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_stable_nxt = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      S_CONFIRM: begin
        if (r_stable_cnt == '0) begin
          w_snap_nxt   = pass_in;
          w_stable_nxt = CW'(1);
        end else if (w_mismatch) begin
          // Exhausting retries wins over a simultaneous accept.
          if (r_retry_cnt == RETRY_LAST) begin
            w_result_nxt   = '0;
            w_unstable_nxt = 1'b1;
          end else begin
            w_snap_nxt   = pass_in;
            w_stable_nxt = CW'(1);
            w_retry_nxt  = r_retry_cnt + 1'b1;
          end
        end else if (r_stable_cnt == CONFIRM_N) begin
          w_result_nxt   = r_snap;
          w_unstable_nxt = 1'b0;
        end else begin
          w_stable_nxt = r_stable_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          w_settle_nxt   = '0;
          w_retry_nxt    = '0;
          w_result_nxt   = '0;
          w_unstable_nxt = 1'b0;
        end
      end
      default: begin
        w_settle_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_stable_cnt <= '0;
      r_retry_cnt  <= '0;
      r_snap       <= '0;
      r_result     <= '0;
      r_unstable   <= 1'b0;
    end else begin
      r_settle_cnt <= w_settle_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_snap       <= w_snap_nxt;
      r_result     <= w_result_nxt;
      r_unstable   <= w_unstable_nxt;
    end
  end

`ifdef AES_SELFTEST_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          w_blink_phase_nxt;

  // Phase restarts at 0 on every DONE entry so the first DONE cycle shows the raw result.
  always_comb begin
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
    end else if (r_state == S_DONE) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt   = '0;
        w_blink_phase_nxt = ~r_blink_phase;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end

  assign w_led_fail = {6{w_blink_phase_nxt}};
`else
  assign w_led_fail = 6'h00;
`endif

  // Outputs are computed from next-state values so the registered copies line up with the state.
  always_comb begin
    w_wrap_nxt         = 1'b0;
    w_led_nxt          = 6'h00;
    w_all_pass_nxt     = 1'b0;
    w_unstable_out_nxt = 1'b0;
    w_busy_nxt         = 1'b0;
    w_done_nxt         = 1'b0;
    case (w_state_nxt)
      S_SETTLE, S_CONFIRM: begin
        w_wrap_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt         = 1'b1;
        w_led_nxt          = w_result_nxt | w_led_fail;
        w_all_pass_nxt     = (w_result_nxt == 6'h3F) && !w_unstable_nxt;
        w_unstable_out_nxt = w_unstable_nxt;
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_enable <= 1'b0;
      led         <= 6'h00;
      all_pass    <= 1'b0;
      unstable    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      wrap_enable <= w_wrap_nxt;
      led         <= w_led_nxt;
      all_pass    <= w_all_pass_nxt;
      unstable    <= w_unstable_out_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_aes_selftest_monitor.sv
// Directed bench for aes_selftest_monitor with SETTLE=4, CONFIRM=3, RETRIES=2, BLINK_HALF=5.
module tb_aes_selftest_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] pass_in;
  logic       wrap_enable;
  logic [5:0] led;
  logic       all_pass;
  logic       unstable;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  aes_selftest_monitor #(
    .SETTLE_CYCLES (4),
    .CONFIRM_CYCLES(3),
    .MAX_RETRIES   (2),
    .BLINK_HALF    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pass_in    (pass_in),
    .wrap_enable(wrap_enable),
    .led        (led),
    .all_pass   (all_pass),
    .unstable   (unstable),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {wrap_enable, led, all_pass, unstable, busy, done}
  function automatic logic [31:0] outs();
    return {21'd0, wrap_enable, led, all_pass, unstable, busy, done};
  endfunction

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    pass_in = 6'h3F;

    // 1: reset dominates a high start
    step(1);
    chk("rst_c1_outs", outs(), 32'd0);
    step(2);
    chk("rst_c3_outs", outs(), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("idle_after_rst", outs(), 32'd0);

    // 2: clean all-pass run
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("run2_e0_wrap", {31'd0, wrap_enable}, 32'd1);
    chk("run2_e0_busy", {31'd0, busy}, 32'd1);
    chk("run2_e0_led", {26'd0, led}, 32'd0);
    for (int e = 1; e <= 7; e++) begin
      step(1);
      chk($sformatf("run2_e%0d_wrap", e), {31'd0, wrap_enable}, 32'd1);
    end
    chk("run2_e7_done", {31'd0, done}, 32'd0);
    step(1);
    chk("run2_e8_outs", outs(), {21'd0, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1});
    step(2);
    chk("run2_hold_done", {31'd0, done}, 32'd1);
    chk("run2_hold_led", {26'd0, led}, 32'h3F);

    // 3: e256 failing
    pass_in = 6'h2F;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    chk("run3_e7_done", {31'd0, done}, 32'd0);
    step(1);
    chk("run3_e8_done", {31'd0, done}, 32'd1);
    chk("run3_e8_led", {26'd0, led}, 32'h2F);
    chk("run3_e8_allpass", {31'd0, all_pass}, 32'd0);
`ifdef AES_SELFTEST_BLINK_EN
    step(5);
    chk("run3_blink_on", {26'd0, led}, 32'h3F);
    step(5);
    chk("run3_blink_off", {26'd0, led}, 32'h2F);
`endif

    // 4: one glitch on the first confirm sample forces a single retry
    pass_in = 6'h3F;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    pass_in = 6'h3E;
    step(1);
    pass_in = 6'h3F;
    step(3);
    chk("run4_e8_done", {31'd0, done}, 32'd0);
    chk("run4_e8_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("run4_e9_outs", outs(), {21'd0, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1});

    // 5: alternating flags exhaust the retry budget
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    pass_in = 6'h3F;
    step(1);
    pass_in = 6'h00;
    step(1);
    chk("run5_e6_done", {31'd0, done}, 32'd0);
    pass_in = 6'h3F;
    step(1);
    chk("run5_e7_outs", outs(), {21'd0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1});

    // relaunch straight from DONE clears the result flags
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("relaunch_outs", outs(), {21'd0, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // 6: reset mid-confirm, then a fresh full-latency run
    step(5);
    chk("run6_confirm_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("run6_rst_outs", outs(), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("run6_idle_outs", outs(), 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    chk("run6_e7_done", {31'd0, done}, 32'd0);
    step(1);
    chk("run6_e8_outs", outs(), {21'd0, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
